// File: rtl/adder_8b_pkg.sv
// adder_8b_pkg: shared defaults and helpers for the adder_8b slice.
// The overflow behaviour is selected by the ADDER_SATURATE_EN macro.
package adder_8b_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_INC   = 1;

    // All-ones value for the given width, right-aligned in a 64-bit word.
    function automatic logic [63:0] all_ones(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage : adder_8b_pkg

// File: rtl/adder_8b_core.sv
// adder_8b_core: combinational A + inc with optional saturation.
// Macro ADDER_SATURATE_EN clamps the result to all-ones on overflow;
// without it the result wraps modulo 2^WIDTH. Carry is the raw MSB carry
// in both builds.
module adder_8b_core
    import adder_8b_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

`ifdef ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_VALUE = WIDTH'(all_ones(WIDTH));
`endif

    logic [WIDTH:0] full_sum;

    // Widened add, then select wrapped or clamped low bits.
    always_comb begin
        full_sum = {1'b0, A} + {1'b0, inc};
        carry    = full_sum[WIDTH];
`ifdef ADDER_SATURATE_EN
        sum      = full_sum[WIDTH] ? SAT_VALUE : full_sum[WIDTH-1:0];
`else
        sum      = full_sum[WIDTH-1:0];
`endif
    end

endmodule : adder_8b_core

// File: rtl/adder_8b.sv
// adder_8b: registered A + INC with one-cycle latency and a valid strobe.
// Overflow handling is selected by macro ADDER_SATURATE_EN (see core).
module adder_8b
    import adder_8b_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned INC   = DEFAULT_INC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry_out
);

    // Only the low WIDTH bits of the increment take part in the add.
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] core_sum;
    logic             core_carry;

    logic [WIDTH-1:0] out_d,   out_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;

    adder_8b_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A     (A),
        .inc   (INC_W),
        .sum   (core_sum),
        .carry (core_carry)
    );

    // Capture a new result on valid input, otherwise hold; strobe is one cycle.
    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        if (in_valid) begin
            out_d   = core_sum;
            carry_d = core_carry;
            valid_d = 1'b1;
        end
    end

    // Output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_q;
    assign out_valid = valid_q;

endmodule : adder_8b

// File: tb/tb_adder_8b.sv
// tb_adder_8b: directed checks of adder_8b with INC=1 and INC=5.
// Expected values follow ADDER_SATURATE_EN when the macro is defined.
module tb_adder_8b;

    logic       clk;
    logic       reset_n;
    logic [7:0] a1, a2;
    logic       iv1, iv2;
    logic [7:0] out1, out2;
    logic       vld1, vld2;
    logic       cout1, cout2;

    int n_checks;
    int n_fail;

    adder_8b #(.WIDTH(8), .INC(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .A(a1), .in_valid(iv1),
        .out(out1), .out_valid(vld1), .carry_out(cout1)
    );

    adder_8b #(.WIDTH(8), .INC(5)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .A(a2), .in_valid(iv2),
        .out(out2), .out_valid(vld2), .carry_out(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a1 = 8'h33; iv1 = 1'b1;
        a2 = 8'h44; iv2 = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out1 !== 8'h00 || cout1 !== 1'b0 || vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut1: got out=%h c=%b v=%b, want out=00 c=0 v=0", out1, cout1, vld1);
        end
        n_checks++;
        if (out2 !== 8'h00 || cout2 !== 1'b0 || vld2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut2: got out=%h c=%b v=%b, want out=00 c=0 v=0", out2, cout2, vld2);
        end
        iv1 = 1'b0; iv2 = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        // First valid after release is processed normally.
        a1 = 8'h0A; iv1 = 1'b1;
        tick();
        n_checks++;
        if (out1 !== 8'h0B || cout1 !== 1'b0 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_result: got out=%h c=%b v=%b, want out=0b c=0 v=1", out1, cout1, vld1);
        end
        iv1 = 1'b0; a1 = 8'hEE;
        tick();
        n_checks++;
        if (out1 !== 8'h0B || vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_strobe_drop: got out=%h v=%b, want out=0b v=0", out1, vld1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ff;
`ifdef ADDER_SATURATE_EN
        exp_ff = 8'hFF;
`else
        exp_ff = 8'h00;
`endif
        a1 = 8'hFF; iv1 = 1'b1;
        tick();
        n_checks++;
        if (out1 !== exp_ff || cout1 !== 1'b1 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_ff: got out=%h c=%b v=%b, want out=%h c=1 v=1", out1, cout1, vld1, exp_ff);
        end
        // Hold with carry set: A changes but in_valid is low.
        iv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = 8'h5A + 8'(i);
            tick();
            n_checks++;
            if (out1 !== exp_ff || cout1 !== 1'b1 || vld1 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_after_ovf[%0d]: got out=%h c=%b v=%b, want out=%h c=1 v=0", i, out1, cout1, vld1, exp_ff);
            end
        end
        a1 = 8'h00; iv1 = 1'b1;
        tick();
        n_checks++;
        if (out1 !== 8'h01 || cout1 !== 1'b0 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_operand: got out=%h c=%b v=%b, want out=01 c=0 v=1", out1, cout1, vld1);
        end
        a1 = 8'hFE;
        tick();
        n_checks++;
        if (out1 !== 8'hFF || cout1 !== 1'b0 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL below_wrap: got out=%h c=%b v=%b, want out=ff c=0 v=1", out1, cout1, vld1);
        end
        iv1 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins  [3];
        logic [7:0] exps [3];
        ins  = '{8'h10, 8'h20, 8'h30};
        exps = '{8'h11, 8'h21, 8'h31};
        for (int i = 0; i < 3; i++) begin
            a1 = ins[i]; iv1 = 1'b1;
            tick();
            n_checks++;
            if (out1 !== exps[i] || cout1 !== 1'b0 || vld1 !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got out=%h c=%b v=%b, want out=%h c=0 v=1", i, out1, cout1, vld1, exps[i]);
            end
        end
        iv1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a1 = 8'hC0 + 8'(i);
            tick();
            n_checks++;
            if (out1 !== 8'h31 || cout1 !== 1'b0 || vld1 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got out=%h c=%b v=%b, want out=31 c=0 v=0", i, out1, cout1, vld1);
            end
        end
    endtask

    task automatic test_async_reset();
        a1 = 8'h41; iv1 = 1'b1;
        tick();
        n_checks++;
        if (out1 !== 8'h42 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got out=%h v=%b, want out=42 v=1", out1, vld1);
        end
        // Mid-cycle reset, checked well before the next rising edge.
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out1 !== 8'h00 || cout1 !== 1'b0 || vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got out=%h c=%b v=%b, want out=00 c=0 v=0", out1, cout1, vld1);
        end
        // Input presented while in reset is discarded.
        a1 = 8'h55; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        n_checks++;
        if (out1 !== 8'h00 || cout1 !== 1'b0 || vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_in_reset: got out=%h c=%b v=%b, want out=00 c=0 v=0", out1, cout1, vld1);
        end
        a1 = 8'h07; iv1 = 1'b1;
        tick();
        n_checks++;
        if (out1 !== 8'h08 || cout1 !== 1'b0 || vld1 !== 1'b1) begin
            n_fail++;
            $display("FAIL after_release: got out=%h c=%b v=%b, want out=08 c=0 v=1", out1, cout1, vld1);
        end
        iv1 = 1'b0;
        tick();
    endtask

    task automatic test_inc5();
        logic [7:0] exp_fc;
`ifdef ADDER_SATURATE_EN
        exp_fc = 8'hFF;
`else
        exp_fc = 8'h01;
`endif
        a2 = 8'hFC; iv2 = 1'b1;
        tick();
        n_checks++;
        if (out2 !== exp_fc || cout2 !== 1'b1 || vld2 !== 1'b1) begin
            n_fail++;
            $display("FAIL inc5_wrap: got out=%h c=%b v=%b, want out=%h c=1 v=1", out2, cout2, vld2, exp_fc);
        end
        a2 = 8'h00;
        tick();
        n_checks++;
        if (out2 !== 8'h05 || cout2 !== 1'b0 || vld2 !== 1'b1) begin
            n_fail++;
            $display("FAIL inc5_zero: got out=%h c=%b v=%b, want out=05 c=0 v=1", out2, cout2, vld2);
        end
        a2 = 8'hFA;
        tick();
        n_checks++;
        if (out2 !== 8'hFF || cout2 !== 1'b0 || vld2 !== 1'b1) begin
            n_fail++;
            $display("FAIL inc5_edge: got out=%h c=%b v=%b, want out=ff c=0 v=1", out2, cout2, vld2);
        end
        iv2 = 1'b0;
        tick();
        n_checks++;
        if (out2 !== 8'hFF || vld2 !== 1'b0) begin
            n_fail++;
            $display("FAIL inc5_hold: got out=%h v=%b, want out=ff v=0", out2, vld2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        a1 = '0; a2 = '0; iv1 = 1'b0; iv2 = 1'b0;
        test_reset();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_inc5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Runaway guard.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule : tb_adder_8b

// File: doc/adder_8b.md
ADDER_8B -- requirements
Module: adder_8b

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter INC, default 1, unsigned constant added to A; only the low WIDTH bits are used.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 A  input  WIDTH  unsigned operand.
REQ-007 in_valid  input  1  A is sampled on this rising edge when high.
REQ-008 out  output  WIDTH  registered result.
REQ-009 out_valid  output  1  high for one cycle when out holds a new result.
REQ-010 carry_out  output  1  registered carry out of the MSB for the current out.

Function
REQ-011 On a rising clk edge with in_valid=1, the sum SHALL be computed as the (WIDTH+1)-bit unsigned value A + INC.
REQ-012 Latency SHALL be exactly 1 cycle: out, carry_out and out_valid update on the same edge that samples A.
REQ-013 Without saturation, out SHALL be sum[WIDTH-1:0] and carry_out SHALL be sum[WIDTH], giving modulo-2^WIDTH wrap-around.
REQ-014 When in_valid=0 on an edge, out and carry_out SHALL hold their values and out_valid SHALL be 0.
REQ-015 Back-to-back valid inputs SHALL produce one result per cycle with no bubbles.
REQ-016 Boundary: A=all-ones, INC=1 SHALL give out=0 and carry_out=1 (wrap); A=0 SHALL give out=INC and carry_out=0.
REQ-017 No combinational path SHALL exist from A or in_valid to any output.

Reset
REQ-018 reset_n=0 SHALL immediately and asynchronously force out=0, carry_out=0, out_valid=0, independent of clk.
REQ-019 A reset asserted during the cycle an input is sampled SHALL discard that input; no result SHALL appear after release.
REQ-020 After reset_n rises, the first rising edge with in_valid=1 SHALL be processed normally.

Configuration
REQ-021 Macro ADDER_SATURATE_EN SHALL control overflow handling.
REQ-022 With ADDER_SATURATE_EN defined, when sum[WIDTH]=1, out SHALL be all-ones and carry_out SHALL be 1.
REQ-023 Without ADDER_SATURATE_EN, overflow SHALL wrap per REQ-013.
REQ-024 ADDER_SATURATE_EN SHALL NOT change latency, out_valid timing or reset behaviour.

Structure
REQ-025 Package adder_8b_pkg SHALL hold the default WIDTH, the default INC and a function returning the all-ones saturation value for a width.
REQ-026 Combinational sum and saturation logic SHALL be in sub-module adder_8b_core: inputs A and the increment; outputs sum and carry.
REQ-027 adder_8b SHALL contain only the output registers and valid logic around adder_8b_core.

Verification
REQ-028 Reset held low, then released; A=0x0A, in_valid=1 for one edge -> next cycle out=0x0B, carry_out=0, out_valid=1, then out_valid=0.
REQ-029 A=0xFF, in_valid=1 -> out=0x00, carry_out=1 without the macro; out=0xFF, carry_out=1 with ADDER_SATURATE_EN.
REQ-030 A=0x10,0x20,0x30 on consecutive edges with in_valid=1 -> out=0x11,0x21,0x31 on consecutive cycles, out_valid held high.
REQ-031 in_valid=0 with A changing -> out and carry_out unchanged, out_valid=0.
REQ-032 reset_n pulled low mid-cycle after out=0x42 -> out=0x00, out_valid=0, carry_out=0 before the next clk edge.
REQ-033 INC=5, A=0xFC -> out=0x01, carry_out=1 (wrap); INC=5, A=0x00 -> out=0x05, carry_out=0.
